neuron_mac: RTL

Sequential Q16.16 signed multiply-accumulate neuron front end. Consumes a stream of (activation, weight) pairs, accumulates their products on top of a bias, and presents one 32-bit pre-activation sum per neuron to the downstream `sigmoid_approx_fn` stage. Sits directly upstream of the sigmoid in every layer datapath. Valid/ready handshakes are used on both sides.

---
 rtl/neuron_mac.sv | 131 +++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// Q16.16 signed multiply-accumulate neuron front end: bias + sum of N_INPUTS x*w products.
// Optional macro NEURON_MAC_SATURATE_EN clamps the 32-bit result instead of wrapping it.
module neuron_mac #(
  parameter int N_INPUTS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_w,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        busy
);

  localparam int CW = 17;
  localparam logic [CW-1:0] N_LIM = CW'(N_INPUTS);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pv_q, pv_d;
  logic signed [63:0] prod_q, prod_d;
  logic signed [63:0] acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_sum_q, out_sum_d;

  logic               accept;
  logic signed [31:0] x_s, w_s;
  logic signed [63:0] prod_full;
  logic               prod_lsb_unused;
  logic [31:0]        result;

  assign in_ready  = (state_q == ACCUM) && (cnt_q < N_LIM);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  assign x_s       = in_x;
  assign w_s       = in_w;
  assign prod_full = x_s * w_s;
  assign prod_lsb_unused = ^prod_full[15:0];

  // Result formatting of the accumulator value that will be current after this edge.
  always_comb begin
`ifdef NEURON_MAC_SATURATE_EN
    if ((acc_d[63:31] == '0) || (acc_d[63:31] == '1)) begin
      result = acc_d[31:0];
    end else begin
      result = acc_d[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`else
    result = acc_d[31:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pv_d        = 1'b0;
    prod_d      = prod_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;

    if (pv_q) begin
      acc_d = acc_q + prod_q;
    end
    // Arithmetic shift keeps floor rounding for negative products.
    if (accept) begin
      prod_d = {{16{prod_full[63]}}, prod_full[63:16]};
      pv_d   = 1'b1;
      cnt_d  = cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = {{32{bias[31]}}, bias};
          cnt_d   = '0;
          pv_d    = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && (cnt_q == N_LIM - CW'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        out_sum_d   = result;
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pv_q        <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pv_q        <= pv_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

endmodule
